// File: rtl/ctrl_decode_queue_pkg.sv
// Shared types for the registered control decoder: mini_op encodings, select codes and queue entry layout.
// The optional illegal-op trap (macro ILLEGAL_TRAP_EN) reuses the entry's illegal flag.
package ctrl_decode_queue_pkg;

  typedef enum logic [3:0] {
    OP_R     = 4'b0000,
    OP_I_L   = 4'b0001,
    OP_I_A   = 4'b0010,
    OP_JALR  = 4'b0011,
    OP_S     = 4'b0100,
    OP_B     = 4'b0101,
    OP_LUI   = 4'b0110,
    OP_AUIPC = 4'b0111,
    OP_JAL   = 4'b1000
  } mini_op_e;

  localparam logic [1:0] WSEL_WORD = 2'b00;
  localparam logic [1:0] WSEL_BYTE = 2'b01;
  localparam logic [1:0] WSEL_HALF = 2'b11;

  localparam logic [2:0] RSEL_WORD = 3'b000;
  localparam logic [2:0] RSEL_B    = 3'b001;
  localparam logic [2:0] RSEL_H    = 3'b010;
  localparam logic [2:0] RSEL_BU   = 3'b011;
  localparam logic [2:0] RSEL_HU   = 3'b100;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam int BUNDLE_W = 12;

  typedef struct packed {
    logic       pc_sel;
    logic       reg_wen;
    logic       a_sel;
    logic       b_sel;
    logic [1:0] data_wsel;
    logic       mem_rw;
    logic [2:0] data_rsel;
    logic [1:0] wb_sel;
  } bundle_t;

  typedef struct packed {
    bundle_t bundle;
    logic    br_err;
    logic    illegal;
  } entry_t;

  function automatic logic [1:0] store_wsel(input logic [2:0] f);
    if (f[1:0] == 2'b00) return WSEL_BYTE;
    if (f[0])            return WSEL_HALF;
    return WSEL_WORD;
  endfunction

  function automatic logic [2:0] load_rsel(input logic [2:0] f);
    if (f == 3'b000)        return RSEL_B;
    if (!f[2] && f[0])      return RSEL_H;
    if (f[2] && !f[0])      return RSEL_BU;
    if (f[2] && f[0])       return RSEL_HU;
    return RSEL_WORD;
  endfunction

endpackage

// File: rtl/ctrl_decode_queue_if.sv
// Handshake and control-bundle bus between the format decoder, the decode queue and the execute stage.
// With ILLEGAL_TRAP_EN defined the bus also carries illegal and illegal_seen.
interface ctrl_decode_queue_if;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] mini_op;
  logic [2:0] funct;
  logic       br_eq;
  logic       br_lt;
  logic       out_valid;
  logic       out_ready;
  logic       pc_sel;
  logic       reg_wen;
  logic       a_sel;
  logic       b_sel;
  logic [1:0] data_wsel;
  logic       mem_rw;
  logic [2:0] data_rsel;
  logic [1:0] wb_sel;
  logic       br_err;
  logic       redirect;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal;
  logic       illegal_seen;

  modport master (
    output flush, in_valid, mini_op, funct, br_eq, br_lt, out_ready,
    input  in_ready, out_valid, pc_sel, reg_wen, a_sel, b_sel, data_wsel, mem_rw,
           data_rsel, wb_sel, br_err, redirect, illegal, illegal_seen
  );
  modport slave (
    input  flush, in_valid, mini_op, funct, br_eq, br_lt, out_ready,
    output in_ready, out_valid, pc_sel, reg_wen, a_sel, b_sel, data_wsel, mem_rw,
           data_rsel, wb_sel, br_err, redirect, illegal, illegal_seen
  );
`else
  modport master (
    output flush, in_valid, mini_op, funct, br_eq, br_lt, out_ready,
    input  in_ready, out_valid, pc_sel, reg_wen, a_sel, b_sel, data_wsel, mem_rw,
           data_rsel, wb_sel, br_err, redirect
  );
  modport slave (
    input  flush, in_valid, mini_op, funct, br_eq, br_lt, out_ready,
    output in_ready, out_valid, pc_sel, reg_wen, a_sel, b_sel, data_wsel, mem_rw,
           data_rsel, wb_sel, br_err, redirect
  );
`endif
endinterface

// File: rtl/ctrl_decode_queue_bundle_dec.sv
// Pure combinational decode of {mini_op, funct, br_eq, br_lt} into the 12-bit control bundle plus flags.
// Undefined mini_op values yield an all-zero (safe) bundle with the illegal flag set.
module ctrl_decode_queue_bundle_dec
  import ctrl_decode_queue_pkg::*;
(
  input  logic [3:0] mini_op,
  input  logic [2:0] funct,
  input  logic       br_eq,
  input  logic       br_lt,
  output entry_t     ent
);

  logic cmp_bad;
  logic br_taken;

  always_comb begin
    cmp_bad = br_eq & br_lt;
    unique case ({funct[2], funct[0]})
      2'b00:   br_taken = br_eq;
      2'b01:   br_taken = ~br_eq;
      2'b10:   br_taken = br_lt;
      default: br_taken = ~br_lt;
    endcase
  end

  always_comb begin
    ent = '0;
    case (mini_op)
      OP_R: begin
        ent.bundle.reg_wen = 1'b1;
        ent.bundle.wb_sel  = WB_ALU;
      end
      OP_I_L: begin
        ent.bundle.reg_wen   = 1'b1;
        ent.bundle.b_sel     = 1'b1;
        ent.bundle.data_rsel = load_rsel(funct);
        ent.bundle.wb_sel    = WB_MEM;
      end
      OP_I_A, OP_LUI: begin
        ent.bundle.reg_wen = 1'b1;
        ent.bundle.b_sel   = 1'b1;
        ent.bundle.wb_sel  = WB_ALU;
      end
      OP_JALR: begin
        ent.bundle.pc_sel  = 1'b1;
        ent.bundle.reg_wen = 1'b1;
        ent.bundle.b_sel   = 1'b1;
        ent.bundle.wb_sel  = WB_PC4;
      end
      OP_S: begin
        ent.bundle.b_sel     = 1'b1;
        ent.bundle.mem_rw    = 1'b1;
        ent.bundle.data_wsel = store_wsel(funct);
        ent.bundle.wb_sel    = WB_ALU;
      end
      OP_B: begin
        // An invalid comparator never redirects; it is reported on br_err instead.
        ent.bundle.pc_sel = br_taken & ~cmp_bad;
        ent.bundle.a_sel  = 1'b1;
        ent.bundle.b_sel  = 1'b1;
        ent.bundle.wb_sel = WB_ALU;
        ent.br_err        = cmp_bad;
      end
      OP_AUIPC: begin
        ent.bundle.reg_wen = 1'b1;
        ent.bundle.a_sel   = 1'b1;
        ent.bundle.b_sel   = 1'b1;
        ent.bundle.wb_sel  = WB_ALU;
      end
      OP_JAL: begin
        ent.bundle.pc_sel  = 1'b1;
        ent.bundle.reg_wen = 1'b1;
        ent.bundle.a_sel   = 1'b1;
        ent.bundle.b_sel   = 1'b1;
        ent.bundle.wb_sel  = WB_PC4;
      end
      default: ent.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_decode_queue.sv
// Registered control decoder: decodes accepted instructions into a DEPTH-entry FIFO with branch-shadow
// squashing, synchronous flush and redirect pulse. Optional feature macro: ILLEGAL_TRAP_EN.
module ctrl_decode_queue
  import ctrl_decode_queue_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int SHADOW = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  ctrl_decode_queue_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       shdw_q, shdw_d;
  logic             redirect_q, redirect_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d;
  entry_t           dec_ent;
  entry_t           head_ent;

  logic in_ready;
  logic out_valid;
  logic accept;
  logic squash;
  logic keep;
  logic enq;
  logic deq;

  ctrl_decode_queue_bundle_dec u_dec (
    .mini_op (bus.mini_op),
    .funct   (bus.funct),
    .br_eq   (bus.br_eq),
    .br_lt   (bus.br_lt),
    .ent     (dec_ent)
  );

  // in_ready depends only on registered count, so a full queue stalls even on a same-cycle dequeue.
  assign in_ready  = cnt_q < CNT_W'(DEPTH);
  assign out_valid = cnt_q != '0;

  always_comb begin
    accept = bus.in_valid & in_ready & ~bus.flush;
    squash = shdw_q != 3'd0;
`ifdef ILLEGAL_TRAP_EN
    keep   = 1'b1;
`else
    keep   = ~dec_ent.illegal;
`endif
    enq    = accept & ~squash & keep;
    deq    = out_valid & bus.out_ready & ~bus.flush;
    mem_d  = dec_ent;

    wr_ptr_d   = wr_ptr_q + PTR_W'(enq);
    rd_ptr_d   = rd_ptr_q + PTR_W'(deq);
    cnt_d      = cnt_q + CNT_W'(enq) - CNT_W'(deq);
    redirect_d = enq & dec_ent.bundle.pc_sel;

    shdw_d = shdw_q;
    if (accept) begin
      if (squash)                     shdw_d = shdw_q - 3'd1;
      else if (dec_ent.bundle.pc_sel) shdw_d = 3'(SHADOW);
    end

    if (bus.flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      shdw_d     = 3'd0;
      redirect_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      shdw_q     <= 3'd0;
      redirect_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      shdw_q     <= shdw_d;
      redirect_q <= redirect_d;
    end
  end

  // Entry storage carries no reset; occupancy is tracked by cnt_q and empty outputs are forced to zero.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= mem_d;
  end

  assign head_ent = out_valid ? mem_q[rd_ptr_q] : '0;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.pc_sel    = head_ent.bundle.pc_sel;
  assign bus.reg_wen   = head_ent.bundle.reg_wen;
  assign bus.a_sel     = head_ent.bundle.a_sel;
  assign bus.b_sel     = head_ent.bundle.b_sel;
  assign bus.data_wsel = head_ent.bundle.data_wsel;
  assign bus.mem_rw    = head_ent.bundle.mem_rw;
  assign bus.data_rsel = head_ent.bundle.data_rsel;
  assign bus.wb_sel    = head_ent.bundle.wb_sel;
  assign bus.br_err    = head_ent.br_err;
  assign bus.redirect  = redirect_q;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_seen_q, illegal_seen_d;

  always_comb begin
    illegal_seen_d = illegal_seen_q | (enq & dec_ent.illegal);
    if (bus.flush) illegal_seen_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_seen_q <= 1'b0;
    else        illegal_seen_q <= illegal_seen_d;
  end

  assign bus.illegal      = head_ent.illegal;
  assign bus.illegal_seen = illegal_seen_q;
`else
  logic unused_illegal;
  assign unused_illegal = head_ent.illegal;
`endif

endmodule

// File: tb/tb_ctrl_decode_queue.sv
// Scoreboard bench for ctrl_decode_queue: directed scenarios followed by a random phase.
// Expected bundles come from an independent table model; squashing and flush are modelled in the bench.
module tb_ctrl_decode_queue;

  localparam int DEPTH  = 2;
  localparam int SHADOW = 2;

  localparam logic [3:0] R = 4'd0, IL = 4'd1, IA = 4'd2, JALR = 4'd3, S = 4'd4,
                         B = 4'd5, LUI = 4'd6, AUIPC = 4'd7, JAL = 4'd8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_decode_queue_if bus();

  ctrl_decode_queue #(.DEPTH(DEPTH), .SHADOW(SHADOW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int n_pop  = 0;

  logic [13:0] sb [$];
  int          m_shdw;
  logic        m_redir;
  logic        m_ill_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {illegal, br_err, pc_sel, reg_wen, a_sel, b_sel, data_wsel, mem_rw, data_rsel, wb_sel}
  function automatic logic [13:0] model(input logic [3:0] op, input logic [2:0] f,
                                        input logic eq, input logic lt);
    logic pc, rw, as, bs, mr, err, ill;
    logic [1:0] ws, wb;
    logic [2:0] rs;
    pc = 0; rw = 1; as = 0; bs = 1; mr = 0; err = 0; ill = 0;
    ws = 2'b00; wb = 2'b01; rs = 3'b000;
    case (op)
      R:    bs = 0;
      IL: begin
        wb = 2'b00;
        case (f)
          3'b000:         rs = 3'b001;
          3'b001, 3'b011: rs = 3'b010;
          3'b100, 3'b110: rs = 3'b011;
          3'b101, 3'b111: rs = 3'b100;
          default:        rs = 3'b000;
        endcase
      end
      IA, LUI: ;
      JALR: begin pc = 1; wb = 2'b10; end
      S: begin
        rw = 0; mr = 1;
        case (f)
          3'b000, 3'b100: ws = 2'b01;
          3'b001, 3'b011, 3'b101, 3'b111: ws = 2'b11;
          default: ws = 2'b00;
        endcase
      end
      B: begin
        rw = 0; as = 1;
        if (eq && lt) err = 1;
        else case ({f[2], f[0]})
          2'b00: pc = eq;
          2'b01: pc = !eq;
          2'b10: pc = lt;
          default: pc = !lt;
        endcase
      end
      AUIPC: as = 1;
      JAL: begin pc = 1; as = 1; wb = 2'b10; end
      default: begin
        ill = 1; pc = 0; rw = 0; as = 0; bs = 0; wb = 2'b00;
      end
    endcase
    return {ill, err, pc, rw, as, bs, ws, mr, rs, wb};
  endfunction

  function automatic logic [13:0] observed();
    logic ill;
`ifdef ILLEGAL_TRAP_EN
    ill = bus.illegal;
`else
    ill = 1'b0;
`endif
    return {ill, bus.br_err, bus.pc_sel, bus.reg_wen, bus.a_sel, bus.b_sel, bus.data_wsel,
            bus.mem_rw, bus.data_rsel, bus.wb_sel};
  endfunction

  function automatic bit trap_en();
`ifdef ILLEGAL_TRAP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_clear();
    sb.delete();
    m_shdw = 0;
    m_redir = 0;
    m_ill_seen = 0;
  endtask

  // One clock: drive after the falling edge, check state-derived outputs, then advance the model.
  task automatic cyc(input logic iv, input logic [3:0] op, input logic [2:0] f,
                     input logic eq, input logic lt, input logic ordy, input logic fl);
    logic [13:0] e, head;
    logic acc;
    @(negedge clk);
    bus.in_valid = iv; bus.mini_op = op; bus.funct = f; bus.br_eq = eq; bus.br_lt = lt;
    bus.out_ready = ordy; bus.flush = fl;
    #1;
    check("in_ready", bus.in_ready, sb.size() < DEPTH);
    check("out_valid", bus.out_valid, sb.size() != 0);
    check("redirect", bus.redirect, m_redir);
`ifdef ILLEGAL_TRAP_EN
    check("illegal_seen", bus.illegal_seen, m_ill_seen);
`endif
    if (sb.size() == 0) check("empty_bundle", observed(), 14'h0);
    if (fl) begin
      model_clear();
    end else begin
      acc = iv && (sb.size() < DEPTH);
      if (ordy && sb.size() != 0) begin
        head = sb.pop_front();
        check("head", observed(), head);
        n_pop++;
      end
      m_redir = 0;
      if (acc) begin
        e = model(op, f, eq, lt);
        if (m_shdw != 0) begin
          m_shdw--;
        end else if (!e[13] || trap_en()) begin
          sb.push_back(e);
          if (e[11]) begin m_redir = 1; m_shdw = SHADOW; end
          if (e[13]) m_ill_seen = 1;
        end
      end
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cyc(0, R, 3'd0, 0, 0, ordy, 0);
  endtask

  int n0;

  initial begin
    bus.flush = 0; bus.in_valid = 0; bus.mini_op = 0; bus.funct = 0;
    bus.br_eq = 0; bus.br_lt = 0; bus.out_ready = 0;
    model_clear();
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_redirect", bus.redirect, 0);
    check("rst_bundle", observed(), 14'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", bus.in_ready, 1);

    // JAL: one-cycle latency, redirect pulse; flush clears the pending shadow
    cyc(1, JAL, 3'd0, 0, 0, 0, 0);
    check("jal_redirect_now", bus.redirect, 0);
    cyc(0, R, 3'd0, 0, 0, 1, 0);
    cyc(0, R, 3'd0, 0, 0, 1, 1);

    // Shadow: JAL then three R ops, only the third R survives
    n0 = n_pop;
    cyc(1, JAL, 3'd0, 0, 0, 1, 0);
    cyc(1, R, 3'd1, 0, 0, 1, 0);
    cyc(1, R, 3'd2, 0, 0, 1, 0);
    cyc(1, R, 3'd3, 0, 0, 1, 0);
    idle(3, 1);
    check("shadow_pops", n_pop - n0, 2);

    // Branches: taken bne, filler squashed, invalid comparator, blt/bge
    cyc(1, B, 3'b001, 0, 0, 1, 0);
    cyc(1, R, 3'd0, 0, 0, 1, 0);
    cyc(1, IA, 3'd0, 0, 0, 1, 0);
    cyc(1, B, 3'b000, 1, 1, 1, 0);
    cyc(1, B, 3'b101, 0, 1, 1, 0);
    cyc(1, B, 3'b100, 0, 1, 1, 0);
    idle(3, 1);
    cyc(0, R, 3'd0, 0, 0, 1, 1);

    // Full queue: three stores with the consumer stalled
    cyc(1, S, 3'b000, 0, 0, 0, 0);
    cyc(1, S, 3'b001, 0, 0, 0, 0);
    cyc(1, S, 3'b010, 0, 0, 0, 0);
    check("full_in_ready", bus.in_ready, 0);
    cyc(1, S, 3'b010, 0, 0, 1, 0);
    cyc(1, S, 3'b010, 0, 0, 1, 0);
    idle(3, 1);

    // Flush with a queued pair and a same-cycle accept
    cyc(1, LUI, 3'd0, 0, 0, 0, 0);
    cyc(1, AUIPC, 3'd0, 0, 0, 0, 0);
    cyc(1, R, 3'd0, 0, 0, 0, 1);
    cyc(1, JALR, 3'd0, 0, 0, 0, 0);
    cyc(0, R, 3'd0, 0, 0, 0, 1);
    n0 = n_pop;
    cyc(1, R, 3'd0, 0, 0, 1, 0);
    idle(2, 1);
    check("post_flush_pops", n_pop - n0, 1);

    // Loads and an illegal op
    cyc(1, IL, 3'b100, 0, 0, 1, 0);
    cyc(1, IL, 3'b101, 0, 0, 1, 0);
    cyc(1, 4'b1010, 3'b000, 0, 0, 1, 0);
    cyc(1, IL, 3'b010, 0, 0, 1, 0);
    idle(3, 1);

    // Asynchronous reset with entries queued
    cyc(1, R, 3'd0, 0, 0, 0, 0);
    cyc(1, IA, 3'd0, 0, 0, 0, 0);
    @(negedge clk);
    bus.in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_redirect", bus.redirect, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
      cyc($urandom_range(0, 3) != 0, op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    end
    idle(DEPTH + 2, 1);
    check("final_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
